// File: rtl/ld_align_if.sv
// Bundles the request, data-memory and response handshakes of ld_align_unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface ld_align_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_func3;
    logic [XLEN-1:0] req_addr;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_fault;

    modport slave (
        input  req_valid, req_func3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_fault
    );

    modport master (
        output req_valid, req_func3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/ld_align_unit.sv
// Sequential load aligner: word-aligned reads, byte/half/word/double extraction and extension.
// Define LD_ALIGN_MISALIGN_EN to allow unaligned loads (word-crossing ones take two reads).
module ld_align_unit #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    ld_align_if.slave bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_WAIT0  = 3'd2;
`ifdef LD_ALIGN_MISALIGN_EN
    localparam logic [2:0] S_ISSUE1 = 3'd3;
    localparam logic [2:0] S_WAIT1  = 3'd4;
`endif
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [2:0]      func3_q, func3_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            mem_rd_en_q, mem_rd_en_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_fault_q, rsp_fault_d;
`ifdef LD_ALIGN_MISALIGN_EN
    logic [XLEN-1:0] word0_q, word0_d;
`endif
    logic            misalign;

    function automatic logic [3:0] op_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    op_size = 4'd1;
            2'd1:    op_size = 4'd2;
            2'd2:    op_size = 4'd4;
            default: op_size = 4'd8;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [2:0] f3);
        op_illegal = (f3 == 3'b111) ||
                     ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    // pair = {upper word, lower word}; shift the addressed bytes down, then extend.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                                input logic [OFFW-1:0]   off,
                                                input logic [2:0]        f3);
        logic [XLEN-1:0] w;
        logic [XLEN-1:0] mask;
        logic            sign;
        w = XLEN'(pair >> {off, 3'b000});
        case (op_size(f3))
            4'd1:    begin mask = XLEN'(8'hFF);         sign = w[7];      end
            4'd2:    begin mask = XLEN'(16'hFFFF);      sign = w[15];     end
            4'd4:    begin mask = XLEN'(32'hFFFF_FFFF); sign = w[31];     end
            default: begin mask = '1;                   sign = w[XLEN-1]; end
        endcase
        sign = sign & ~f3[2];
        extract = (w & mask) | ({XLEN{sign}} & ~mask);
    endfunction

`ifdef LD_ALIGN_MISALIGN_EN
    assign misalign = 1'b0;
`else
    assign misalign = (bus.req_addr[OFFW-1:0] &
                       OFFW'(op_size(bus.req_func3) - 4'd1)) != '0;
`endif

    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        off_d       = off_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
`ifdef LD_ALIGN_MISALIGN_EN
        word0_d     = word0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    func3_d = bus.req_func3;
                    off_d   = bus.req_addr[OFFW-1:0];
                    if (op_illegal(bus.req_func3) || misalign) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d     = S_ISSUE0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    end
                end
            end
            S_ISSUE0: state_d = S_WAIT0;
            S_WAIT0: begin
                if (bus.mem_rvalid) begin
`ifdef LD_ALIGN_MISALIGN_EN
                    if ((5'(off_q) + 5'(op_size(func3_q))) > 5'(NB)) begin
                        word0_d     = bus.mem_rdata;
                        state_d     = S_ISSUE1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = mem_addr_q + XLEN'(NB);
                    end else
`endif
                    begin
                        rsp_data_d  = extract({{XLEN{1'b0}}, bus.mem_rdata}, off_q, func3_q);
                        rsp_fault_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
`ifdef LD_ALIGN_MISALIGN_EN
            S_ISSUE1: state_d = S_WAIT1;
            S_WAIT1: begin
                if (bus.mem_rvalid) begin
                    rsp_data_d  = extract({bus.mem_rdata, word0_q}, off_q, func3_q);
                    rsp_fault_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            func3_q     <= 3'd0;
            off_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
`ifdef LD_ALIGN_MISALIGN_EN
            word0_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
`ifdef LD_ALIGN_MISALIGN_EN
            word0_q     <= word0_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: doc/ld_align_unit.md
# ld_align_unit

Sequential load-alignment unit between the MEM stage and the data-memory port. It accepts a load request (func3 plus byte address) and issues one or two word-aligned reads. It then extracts the addressed byte, halfword, word or doubleword, sign- or zero-extends it, and returns it through a valid/ready response. It generalises the combinational load filter: the width is parametrised, offsets are honoured, the memory handshake is handled, and word-crossing loads can optionally be split.

## Interface
- XLEN, 32: data and address width; legal values 32 or 64. NB = XLEN/8 bytes per memory word.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_func3  in  3  000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- req_addr  in  XLEN  byte address.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  XLEN  word-aligned read address (low log2(NB) bits are 0).
- mem_rvalid  in  1  read data valid; arrives 1 or more cycles after mem_rd_en.
- mem_rdata  in  XLEN  read word, little-endian.
- rsp_valid  out  1  result valid; held until rsp_ready.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  XLEN  extended load result.
- rsp_fault  out  1  illegal func3 or disallowed misalignment; rsp_data = 0 when set.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE, on accept: latch func3 and addr. Compute size (1, 2, 4 or 8), off = addr mod NB, and base = addr with the low bits cleared.
  - Illegal func3 (011/110 with XLEN=32, or 111), or a misalignment fault (see Configuration): go to RESP with fault=1, data=0, no memory access.
  - Otherwise go to ISSUE0.
- ISSUE0: mem_rd_en=1, mem_addr=base, then go to WAIT0.
- WAIT0: on mem_rvalid, capture word0.
  - If off+size > NB (split), go to ISSUE1.
  - Otherwise compute the result and go to RESP.
- ISSUE1: mem_rd_en=1, mem_addr = base+NB (modulo 2^XLEN, so it wraps to 0), then go to WAIT1.
- WAIT1: on mem_rvalid, capture word1, compute the result, then go to RESP.
- Extraction: form {word1, word0} (word1 = 0 if not split), shift right by off*8, keep the low size bytes.
  - Signed ops extend bit size*8-1; unsigned ops zero-extend.
  - LW with XLEN=32 and LD with XLEN=64 pass through unextended.
- RESP: rsp_valid=1, with rsp_data and rsp_fault held stable. When rsp_ready is high, go to IDLE and clear rsp_valid.
- mem_rvalid outside WAIT0/WAIT1 is ignored. Only one read is outstanding at a time.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_fault=0, captured words=0.
- All outputs are registered except req_ready, which is decoded from state.
- Aligned load with 1-cycle memory: accept at cycle T, mem_rd_en at T+1, mem_rvalid at T+2, rsp_valid at T+3.
- Split load: 2 cycles more than an aligned load.
- Fault: rsp_valid at T+1.
- rsp_valid && rsp_ready in cycle R: the next request can be accepted at R+1. There is no same-cycle bypass.
- rst in any state takes effect at the next edge. An in-flight mem_rvalid arriving after reset is ignored.

## Configuration
- LD_ALIGN_MISALIGN_EN defined:
  - Any offset is legal.
  - Word-crossing accesses use the two-read path.
  - Non-crossing unaligned accesses use one read.
- Undefined:
  - addr mod size != 0 is a fault (rsp_fault=1, rsp_data=0, no mem_rd_en).
  - ISSUE1 and WAIT1 are unreachable and may be omitted.

## Test plan
- XLEN=32, LB at 0x1003, word 0x80FF1234 → rsp_data=0xFFFFFF80, fault=0. rsp_valid 3 cycles after accept with 1-cycle memory.
- XLEN=32, LHU at 0x2002, word 0xBEEF0000 → 0x0000BEEF. With rsp_ready low for 5 cycles: rsp_valid and rsp_data held, req_ready=0; on handshake, returns to IDLE.
- XLEN=32, LW at 0x3001, words [0x3000]=0x44332211 and [0x3004]=0x88776655:
  - With macro: reads at 0x3000 then 0x3004, result 0x55443322.
  - Without macro: fault=1, data=0, no mem_rd_en.
- XLEN=32 with macro, LW at 0xFFFFFFFE → second read at 0x00000000, words 0xBBAA0000 and 0x0000DDCC → 0xDDCCBBAA.
- XLEN=32, func3=011 → fault=1, data=0 at T+1. XLEN=64, LD at 0x8, word 0x8000000000000001 → the same value; LWU at 0xC with that word → 0x0000000080000000.
- Assert rst in WAIT0, then raise mem_rvalid 2 cycles later → stays in IDLE, rsp_valid=0, all outputs at reset values; a next LB completes normally.
